// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the cpu_controller sequencer.
//   - state_t : FSM state encoding (IDLE, FETCH, DECODE, EXEC, HALTED)
//   - CLS_*   : two-bit instruction class encodings held in the MSBs of IR
//   - instr_width() : instruction word width derived from AW and WIDTH
package cpu_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_NOP     = 2'b10;
  localparam logic [1:0] CLS_HALT    = 2'b11;

  // Word layout, MSB first: cls[2] op[3] rd[AW] rs1[AW] rs2[AW] imm[WIDTH]
  function automatic int instr_width(input int aw, input int width);
    return 5 + 3 * aw + width;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Purely combinational instruction field splitter.
// Ports:
//   ir       in  INSTR_W  instruction register contents
//   cls      out 2        instruction class
//   alu_sel  out 3        ALU operation (op field)
//   mux_sel  out 1        operand B select: 1 = immediate (cls[0])
//   rd       out AW       destination register
//   rs1      out AW       source register A
//   rs2      out AW       source register B
//   imm      out WIDTH    immediate operand
module cpu_ctrl_decode
  import cpu_controller_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int AW      = 3,
  parameter int INSTR_W = instr_width(AW, WIDTH)
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [1:0]         cls,
  output logic [2:0]         alu_sel,
  output logic               mux_sel,
  output logic [AW-1:0]      rd,
  output logic [AW-1:0]      rs1,
  output logic [AW-1:0]      rs2,
  output logic [WIDTH-1:0]   imm
);

  localparam int RS2_LSB = WIDTH;
  localparam int RS1_LSB = WIDTH + AW;
  localparam int RD_LSB  = WIDTH + 2 * AW;
  localparam int OP_LSB  = WIDTH + 3 * AW;
  localparam int CLS_LSB = OP_LSB + 3;

  assign cls     = ir[CLS_LSB +: 2];
  assign alu_sel = ir[OP_LSB +: 3];
  assign rd      = ir[RD_LSB +: AW];
  assign rs1     = ir[RS1_LSB +: AW];
  assign rs2     = ir[RS2_LSB +: AW];
  assign imm     = ir[0 +: WIDTH];
  // cls 01 (ALU-imm) is the only ALU class with bit 0 set.
  assign mux_sel = cls[0];

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle sequencer for the mini CPU datapath. Fetches instruction words
// over a req/valid handshake, decodes them and drives one register-file write
// per ALU instruction. Datapath controls decode straight from IR, so they only
// change when IR is loaded and stay stable through DECODE and EXEC.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             begin at PC=0 (honoured in IDLE or HALTED only)
//   imem_req/addr     fetch request and address (= PC)
//   imem_valid/data   instruction return, accepted only in FETCH
//   write_en          register write strobe, high for the EXEC cycle only
//   write_addr, read_addr1, read_addr2, alu_sel, mux_sel, immediate_data
//                     datapath controls decoded from IR
//   carry_out         datapath ALU carry, captured at the end of EXEC
//   carry_flag        carry of the last executed ALU instruction
//   busy, halted      status (FETCH/DECODE/EXEC, HALTED)
//   retired           16-bit wrapping count of executed ALU instructions
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int REG_COUNT = 8,
  parameter  int PC_W      = 8,
  localparam int AW        = $clog2(REG_COUNT),
  localparam int INSTR_W   = instr_width(AW, WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               write_en,
  output logic [AW-1:0]      write_addr,
  output logic [AW-1:0]      read_addr1,
  output logic [AW-1:0]      read_addr2,
  output logic [2:0]         alu_sel,
  output logic               mux_sel,
  output logic [WIDTH-1:0]   immediate_data,
  input  logic               carry_out,
  output logic               carry_flag,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired
);

  state_t             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic               carry_reg, carry_next;
  logic [15:0]        retired_reg, retired_next;
  logic [1:0]         cls;

  cpu_ctrl_decode #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_decode (
    .ir      (ir_reg),
    .cls     (cls),
    .alu_sel (alu_sel),
    .mux_sel (mux_sel),
    .rd      (write_addr),
    .rs1     (read_addr1),
    .rs2     (read_addr2),
    .imm     (immediate_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      carry_reg   <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      carry_reg   <= carry_next;
      retired_reg <= retired_next;
    end
  end

  // Strobes come from the state register alone, so an asynchronous reset
  // removes write_en/imem_req without waiting for a clock edge.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    carry_next   = carry_reg;
    retired_next = retired_reg;
    imem_req     = 1'b0;
    write_en     = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_next    = imem_data;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        case (cls)
          CLS_ALU_REG, CLS_ALU_IMM: state_next = S_EXEC;
          CLS_NOP: begin
            pc_next    = pc_reg + 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_HALTED;
        endcase
      end
      S_EXEC: begin
        busy         = 1'b1;
        write_en     = 1'b1;
        carry_next   = carry_out;
        retired_next = retired_reg + 16'd1;
        pc_next      = pc_reg + 1'b1;
        state_next   = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) begin
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_addr  = pc_reg;
  assign carry_flag = carry_reg;
  assign retired    = retired_reg;

endmodule
